// File: rtl/jt51_pkg.sv
// Shared jt51 definitions.
// Slot index width, default base clamp and the half-step multiplier code.
package jt51_pkg;

   localparam int BASE_MAX_DEF = 82976;
   localparam logic [3:0] MUL_HALF = 4'd0;

   function automatic int slot_w(input int slots);
      return $clog2(slots);
   endfunction

endpackage

// File: rtl/jt51_pg_store.sv
// Per-slot phase accumulator storage with stage-D read-modify-write.
// Preset load beats hold, which beats accumulation.
module jt51_pg_store
   import jt51_pkg::*;
#(
   parameter int SLOTS = 32,
   parameter int PHW   = 20,
   parameter int OUTW  = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cen,
   input  logic [slot_w(SLOTS)-1:0] slot,
   input  logic                     key_rst,
   input  logic                     hold,
   input  logic [OUTW-1:0]          preset,
   input  logic [PHW-1:0]           step,
   output logic [OUTW-1:0]          phase_out,
   output logic [slot_w(SLOTS)-1:0] slot_out
);

   localparam int SW = slot_w(SLOTS);

   logic [PHW-1:0]  acc_q [SLOTS];
   logic [PHW-1:0]  cur;
   logic [PHW-1:0]  nxt;
   logic [OUTW-1:0] phase_d, phase_q;
   logic [SW-1:0]   slot_d, slot_q;

   always_comb begin
      cur = acc_q[slot];
      nxt = cur + step;
      if (key_rst) begin
         nxt = PHW'(preset) << (PHW - OUTW);
      end else if (hold) begin
         nxt = cur;
      end
      phase_d = nxt[PHW-1 -: OUTW];
      slot_d  = slot;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOTS; i++) acc_q[i] <= '0;
         phase_q <= '0;
         slot_q  <= '0;
      end else if (cen) begin
         acc_q[slot] <= nxt;
         phase_q     <= phase_d;
         slot_q      <= slot_d;
      end
   end

   assign phase_out = phase_q;
   assign slot_out  = slot_q;

endmodule

// File: rtl/jt51_pg_mslot.sv
// Time-multiplexed phase generator: slot counter and stages A-C
// (latch, clamp+detune, multiply) feeding the accumulator store.
module jt51_pg_mslot
   import jt51_pkg::*;
#(
   parameter int SLOTS    = 32,
   parameter int PHW      = 20,
   parameter int OUTW     = 10,
   parameter int BASEW    = 18,
   parameter int BASE_MAX = BASE_MAX_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cen,
   input  logic [BASEW-1:0]         base_in,
   input  logic [4:0]               dt_off,
   input  logic                     dt_neg,
   input  logic [3:0]               mul,
   input  logic                     key_rst,
   input  logic [OUTW-1:0]          preset,
   input  logic                     hold,
   output logic [slot_w(SLOTS)-1:0] slot_in,
   output logic                     zero,
   output logic [OUTW-1:0]          phase_out,
   output logic [slot_w(SLOTS)-1:0] slot_out
);

   localparam int SW = slot_w(SLOTS);
   localparam int DW = BASEW + 2;
   localparam int PW = (DW + 4 > PHW) ? DW + 4 : PHW;
   localparam int CW = 2 + OUTW + SW;
   localparam logic [DW-1:0] CLAMP = DW'(BASE_MAX);

   logic [SW-1:0]    cnt_d, cnt_q;
   logic [BASEW-1:0] base_a_d, base_a_q;
   logic [4:0]       dt_a_d, dt_a_q;
   logic             neg_a_d, neg_a_q;
   logic [3:0]       mul_a_d, mul_a_q, mul_b_d, mul_b_q;
   logic [CW-1:0]    ctl_a_d, ctl_a_q;
   logic [CW-1:0]    ctl_b_d, ctl_b_q;
   logic [CW-1:0]    ctl_c_d, ctl_c_q;
   logic [DW-1:0]    clamp, dtx;
   logic [DW-1:0]    det_b_d, det_b_q;
   logic [PHW-1:0]   step_c_d, step_c_q;

   always_comb begin
      cnt_d    = cnt_q + SW'(1);
      base_a_d = base_in;
      dt_a_d   = dt_off;
      neg_a_d  = dt_neg;
      mul_a_d  = mul;
      ctl_a_d  = {key_rst, hold, preset, cnt_q};
   end

   // Clamp first so the detune always applies to an in-range base.
   always_comb begin
      clamp = (DW'(base_a_q) > CLAMP) ? CLAMP : DW'(base_a_q);
      dtx   = DW'(dt_a_q);
      if (!neg_a_q) begin
         det_b_d = clamp + dtx;
      end else begin
         det_b_d = (clamp > dtx) ? clamp - dtx : '0;
      end
      mul_b_d = mul_a_q;
      ctl_b_d = ctl_a_q;
   end

   always_comb begin
      if (mul_b_q == MUL_HALF) begin
         step_c_d = PHW'(det_b_q >> 1);
      end else begin
         step_c_d = PHW'(PW'(det_b_q) * PW'(mul_b_q));
      end
      ctl_c_d = ctl_b_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         base_a_q <= '0;
         dt_a_q   <= '0;
         neg_a_q  <= 1'b0;
         mul_a_q  <= '0;
         ctl_a_q  <= '0;
         det_b_q  <= '0;
         mul_b_q  <= '0;
         ctl_b_q  <= '0;
         step_c_q <= '0;
         ctl_c_q  <= '0;
      end else if (cen) begin
         cnt_q    <= cnt_d;
         base_a_q <= base_a_d;
         dt_a_q   <= dt_a_d;
         neg_a_q  <= neg_a_d;
         mul_a_q  <= mul_a_d;
         ctl_a_q  <= ctl_a_d;
         det_b_q  <= det_b_d;
         mul_b_q  <= mul_b_d;
         ctl_b_q  <= ctl_b_d;
         step_c_q <= step_c_d;
         ctl_c_q  <= ctl_c_d;
      end
   end

   assign slot_in = cnt_q;
   assign zero    = (cnt_q == '0);

   jt51_pg_store #(
      .SLOTS (SLOTS),
      .PHW   (PHW),
      .OUTW  (OUTW)
   ) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .cen       (cen),
      .slot      (ctl_c_q[SW-1:0]),
      .key_rst   (ctl_c_q[CW-1]),
      .hold      (ctl_c_q[CW-2]),
      .preset    (ctl_c_q[SW +: OUTW]),
      .step      (step_c_q),
      .phase_out (phase_out),
      .slot_out  (slot_out)
   );

endmodule
